axi_fifo_bridge: RTL and testbench
==================================

// Module: axi_fifo_bridge
// PURPOSE
//  AXI4-Lite slave exposing one TX FIFO (AXI->core) and one RX FIFO (core->AXI) as a register map; parametrised successor to the UART FIFO bridge.
//  Adds: parametrised width/depth, level counters, flush, programmable thresholds, sticky error flags, level IRQ, SLVERR responses.
//  Sits between the AXI interconnect and a serial engine (UART/SPI), which drains TX and fills RX.
// PARAMETERS
//  DATA_WIDTH  32  AXI data and FIFO word width; multiple of 8, >= 32
//  ADDR_WIDTH  32  AXI address width; decode uses ADDR[4:2] only
//  DEPTH       16  entries per FIFO; power of 2, >= 4
//  LW          $clog2(DEPTH)+1  level width (localparam, not overridable)
// PORTS
//  S_AXI_ACLK     in   1    single clock
//  S_AXI_ARESET   in   1    synchronous reset, active-high
//  S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave set (AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY); PROT ignored
//  tx_pop       in   1           core pops TX head; ignored when tx_empty
//  tx_data      out  DATA_WIDTH  TX head word, valid while !tx_empty (first-word fall-through)
//  tx_empty     out  1           TX level == 0
//  tx_level     out  LW          TX occupancy
//  rx_push      in   1           core pushes rx_data
//  rx_data      in   DATA_WIDTH  RX write word
//  rx_full      out  1           RX level == DEPTH
//  rx_level     out  LW          RX occupancy
//  irq          out  1           registered; |(IRQ_STATUS & IRQ_EN)
// BEHAVIOUR
//  Reset: all READY/VALID low, BRESP/RRESP/RDATA 0, levels 0, pointers 0, CTRL 0, thresholds 0, IRQ_STATUS 0, irq 0; reset mid-transaction drops it (no B/R issued). FIFO RAM is not reset.
//  Register map (byte offset):
//   0x00 W: TX_DATA push (WSTRB ignored); R: TX_STATUS {tx_level, full, empty}
//   0x04 R: RX_DATA pop; W: SLVERR
//   0x08 RW CTRL: [0] tx_flush, [1] rx_flush (self-clear, read 0); [5:2] IRQ_EN
//   0x0C RW THRESH: [15:0] tx_low_thr, [31:16] rx_high_thr
//   0x10 R/W1C IRQ_STATUS: [0] tx_level<=tx_low_thr, [1] rx_level>=rx_high_thr, [2] rx_overflow (sticky), [3] tx_overflow (sticky)
//   0x14-0x1C: read returns 0 with SLVERR; write discarded with SLVERR
//  Write channel: AW and W captured independently; AWREADY/WREADY high while the respective holding register is empty. Write executes in the cycle both are held and !BVALID; BVALID asserts the next cycle and holds until BREADY. Holding registers clear on execution. Max 1 outstanding.
//  TX push when full: word dropped, tx_overflow set, BRESP=SLVERR(2'b10); otherwise OKAY.
//  Read channel: ARREADY high when !RVALID and no AR held. On AR handshake (cycle N), RDATA/RRESP are registered and RVALID=1 at N+1, held stable until RREADY.
//  RX_DATA read: pop occurs at the AR handshake; when empty: RDATA=0, RRESP=SLVERR, no pop.
//  FIFO: level 0..DEPTH; pointers wrap modulo DEPTH. A push while full is accepted only with a same-cycle pop; level is unchanged.
//  rx_push while full with no pop: dropped, rx_overflow set. A pop while empty is a no-op.
//  Flush (CTRL bit written 1): level and pointers go to 0 next cycle. Flush beats a same-cycle push/pop on that FIFO.
//  Level flags [1:0] are recomputed every cycle (W1C has no effect). Sticky [3:2] set/clear in the same cycle: set wins.
//  Threshold compare: LW-bit level vs zero-extended/truncated 16-bit threshold.
// STRUCTURE
//  pkg axi_fifo_pkg: register offset localparams, axi_resp_t enum (OKAY=2'b00, SLVERR=2'b10), IRQ bit indices.
//  Sub-module sync_fifo #(DATA_WIDTH, DEPTH): push/pop/flush, data_out FWFT, level, full, empty, overflow pulse; instantiated twice (TX, RX).
//  Top: AXI handshake FSMs, register decode, IRQ logic.
// TESTING
//  Reset: push 3 TX words, assert reset 1 cycle -> tx_level=0, tx_empty=1, BVALID=0, irq=0.
//  Write AW 2 cycles before W, data 0xA5A5_0001 -> one push, BVALID one cycle after W captured, BRESP=OKAY, tx_data=0xA5A5_0001.
//  Fill TX with 16 words, write a 17th -> BRESP=SLVERR, IRQ_STATUS[3]=1, tx_level=16; W1C 0x8 -> clears.
//  RX: rx_push 0x11, 0x22; read 0x04 twice -> RDATA 0x11 then 0x22, both OKAY; third read -> RDATA=0, SLVERR.
//  RX full plus simultaneous rx_push and AXI pop -> rx_level stays 16, no overflow; wrap order preserved over 40 words.
//  THRESH rx_high=4, IRQ_EN[1]=1; push 4 -> irq=1 the next cycle; write CTRL rx_flush -> rx_level=0, irq=0.

Source files
------------

// File: rtl/axi_fifo_pkg.sv
// rtl/axi_fifo_pkg.sv - register map, response codes and IRQ bit positions for the AXI FIFO bridge
package axi_fifo_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [2:0] REG_TX_DATA    = 3'd0;
    localparam logic [2:0] REG_RX_DATA    = 3'd1;
    localparam logic [2:0] REG_CTRL       = 3'd2;
    localparam logic [2:0] REG_THRESH     = 3'd3;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd4;

    localparam int IRQ_TX_LOW  = 0;
    localparam int IRQ_RX_HIGH = 1;
    localparam int IRQ_RX_OVF  = 2;
    localparam int IRQ_TX_OVF  = 3;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axi_fifo_bridge_if.sv
// rtl/axi_fifo_bridge_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_fifo_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with level, flush and overflow pulse
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int LW        = $clog2(DEPTH) + 1,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO only fits when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign level    = level_q;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_q + {{(LW-1){1'b0}}, do_push} - {{(LW-1){1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/axi_fifo_bridge.sv
// rtl/axi_fifo_bridge.sv - AXI4-Lite register front end for a TX/RX FIFO pair with thresholds and IRQ
module axi_fifo_bridge
    import axi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    axi_fifo_bridge_if.slave      s_axi,
    input  logic                  tx_pop,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_empty,
    output logic [LW-1:0]         tx_level,
    input  logic                  rx_push,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_full,
    output logic [LW-1:0]         rx_level,
    output logic                  irq
);

    logic                  aw_held, w_held, bvalid_q, wr_exec;
    logic [2:0]            aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0] w_data;
    axi_resp_t             bresp_q, wr_resp, rresp_q, rd_resp;
    logic [DATA_WIDTH-1:0] rdata_q, rd_data, rx_head;
    rd_state_t             rd_state, rd_next;
    logic                  ar_hs, rx_pop, tx_full, rx_empty;
    logic                  tx_push, tx_flush, rx_flush, tx_ovf, rx_ovf, ctrl_wr, w1c;
    logic [3:0]            irq_en, irq_status;
    logic                  tx_ovf_s, rx_ovf_s;
    logic [15:0]           tx_low_thr, rx_high_thr;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:0], s_axi.araddr, s_axi.awprot,
                           s_axi.arprot, s_axi.wstrb};

    // Readies are held low while reset is asserted
    assign s_axi.awready = !aw_held && !S_AXI_ARESET;
    assign s_axi.wready  = !w_held && !S_AXI_ARESET;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = (rd_state == RD_IDLE) && !S_AXI_ARESET;
    assign s_axi.rvalid  = (rd_state == RD_RESP);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign wr_exec  = aw_held && w_held && !bvalid_q;
    assign tx_push  = wr_exec && (aw_idx == REG_TX_DATA);
    assign ctrl_wr  = wr_exec && (aw_idx == REG_CTRL);
    assign tx_flush = ctrl_wr && w_data[0];
    assign rx_flush = ctrl_wr && w_data[1];
    assign w1c      = wr_exec && (aw_idx == REG_IRQ_STATUS);

    always_comb begin
        wr_resp = SLVERR;
        case (aw_idx)
            REG_TX_DATA:    wr_resp = tx_ovf ? SLVERR : OKAY;
            REG_RX_DATA:    wr_resp = SLVERR;
            REG_CTRL,
            REG_THRESH,
            REG_IRQ_STATUS: wr_resp = OKAY;
            default:        wr_resp = SLVERR;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            if (s_axi.awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.awaddr[4:2];
            end else if (wr_exec) begin
                aw_held <= 1'b0;
            end
            if (s_axi.wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s_axi.wdata;
            end else if (wr_exec) begin
                w_held <= 1'b0;
            end
            if (wr_exec) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            irq_en      <= '0;
            tx_low_thr  <= '0;
            rx_high_thr <= '0;
            tx_ovf_s    <= 1'b0;
            rx_ovf_s    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= w_data[5:2];
            if (wr_exec && (aw_idx == REG_THRESH)) begin
                tx_low_thr  <= w_data[15:0];
                rx_high_thr <= w_data[31:16];
            end
            // A new overflow in the same cycle as its W1C keeps the flag set
            if (tx_ovf)                           tx_ovf_s <= 1'b1;
            else if (w1c && w_data[IRQ_TX_OVF])   tx_ovf_s <= 1'b0;
            if (rx_ovf)                           rx_ovf_s <= 1'b1;
            else if (w1c && w_data[IRQ_RX_OVF])   rx_ovf_s <= 1'b0;
            irq <= |(irq_status & irq_en);
        end
    end

    always_comb begin
        irq_status              = '0;
        irq_status[IRQ_TX_LOW]  = (tx_level <= LW'(tx_low_thr));
        irq_status[IRQ_RX_HIGH] = (rx_level >= LW'(rx_high_thr));
        irq_status[IRQ_RX_OVF]  = rx_ovf_s;
        irq_status[IRQ_TX_OVF]  = tx_ovf_s;
    end

    assign ar_idx = s_axi.araddr[4:2];
    assign ar_hs  = s_axi.arvalid && (rd_state == RD_IDLE);
    assign rx_pop = ar_hs && (ar_idx == REG_RX_DATA) && !rx_empty;

    always_comb begin
        rd_data = '0;
        rd_resp = OKAY;
        case (ar_idx)
            REG_TX_DATA:    rd_data = DATA_WIDTH'({tx_level, tx_full, tx_empty});
            REG_RX_DATA: begin
                if (rx_empty) rd_resp = SLVERR;
                else          rd_data = rx_head;
            end
            REG_CTRL:       rd_data = DATA_WIDTH'({irq_en, 2'b00});
            REG_THRESH:     rd_data = DATA_WIDTH'({rx_high_thr, tx_low_thr});
            REG_IRQ_STATUS: rd_data = DATA_WIDTH'(irq_status);
            default:        rd_resp = SLVERR;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (s_axi.arvalid) rd_next = RD_RESP;
            RD_RESP: if (s_axi.rready)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk      (S_AXI_ACLK),
        .rst      (S_AXI_ARESET),
        .push     (tx_push),
        .pop      (tx_pop),
        .flush    (tx_flush),
        .data_in  (w_data),
        .data_out (tx_data),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty),
        .overflow (tx_ovf)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk      (S_AXI_ACLK),
        .rst      (S_AXI_ARESET),
        .push     (rx_push),
        .pop      (rx_pop),
        .flush    (rx_flush),
        .data_in  (rx_data),
        .data_out (rx_head),
        .level    (rx_level),
        .full     (rx_full),
        .empty    (rx_empty),
        .overflow (rx_ovf)
    );

endmodule

// File: tb/tb_axi_fifo_bridge.sv
// tb/tb_axi_fifo_bridge.sv - directed self-checking bench for axi_fifo_bridge
module tb_axi_fifo_bridge;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_pop;
    logic [DW-1:0] tx_data;
    logic          tx_empty;
    logic [LW-1:0] tx_level;
    logic          rx_push;
    logic [DW-1:0] rx_data;
    logic          rx_full;
    logic [LW-1:0] rx_level;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_fifo_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_fifo_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .tx_pop       (tx_pop),
        .tx_data      (tx_data),
        .tx_empty     (tx_empty),
        .tx_level     (tx_level),
        .rx_push      (rx_push),
        .rx_data      (rx_data),
        .rx_full      (rx_full),
        .rx_level     (rx_level),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        bit aw_pend, w_pend, aw_go, w_go;
        int n;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        n = 0;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        while ((aw_pend || w_pend) && n < 50) begin
            aw_go = aw_pend && bus.awready;
            w_go  = w_pend && bus.wready;
            tick();
            if (aw_go) begin aw_pend = 1'b0; bus.awvalid = 1'b0; end
            if (w_go)  begin w_pend = 1'b0;  bus.wvalid = 1'b0;  end
            n++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_accept", {31'b0, !(aw_pend || w_pend)}, 32'd1);
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin tick(); n++; end
        check("wr_bvalid", {31'b0, bus.bvalid}, 32'd1);
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input bit push_en, input logic [31:0] push_val,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin tick(); n++; end
        check("rd_accept", {31'b0, bus.arready}, 32'd1);
        if (push_en) begin
            rx_push = 1'b1;
            rx_data = push_val;
        end
        tick();
        bus.arvalid = 1'b0;
        rx_push     = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 50) begin tick(); n++; end
        check("rd_rvalid", {31'b0, bus.rvalid}, 32'd1);
        data = bus.rdata;
        resp = bus.rresp;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] tx_exp [16];

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset drops queued TX words and quiets the bus
        for (int i = 1; i <= 3; i++) axi_write(32'h00, i, resp);
        check("pre_rst_tx_level", tx_level, 32'd3);
        rst = 1'b1;
        #1;
        check("rst_awready", {31'b0, bus.awready}, 32'd0);
        check("rst_arready", {31'b0, bus.arready}, 32'd0);
        tick();
        rst = 1'b0;
        check("rst_tx_level", tx_level, 32'd0);
        check("rst_tx_empty", tx_empty, 32'd1);
        check("rst_bvalid", bus.bvalid, 32'd0);
        check("rst_irq", irq, 32'd0);

        // AW leads W by two cycles
        bus.awaddr = 32'h00; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("aw_held_ready", bus.awready, 32'd0);
        tick();
        bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("bvalid_not_yet", bus.bvalid, 32'd0);
        tick();
        check("bvalid_up", bus.bvalid, 32'd1);
        check("bresp_okay", bus.bresp, 32'd0);
        check("tx_level_1", tx_level, 32'd1);
        check("tx_data_head", tx_data, 32'hA5A5_0001);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;

        // Fill TX, then overflow it
        tx_exp[0] = 32'hA5A5_0001;
        for (int i = 1; i < 16; i++) begin
            tx_exp[i] = 32'h100 + i;
            axi_write(32'h00, tx_exp[i], resp);
        end
        check("tx_level_full", tx_level, 32'd16);
        axi_read(32'h00, 1'b0, '0, rd, resp);
        check("tx_status_full", rd, 32'h42);
        axi_write(32'h00, 32'hDEAD_BEEF, resp);
        check("tx_ovf_resp", resp, 32'd2);
        check("tx_level_after_ovf", tx_level, 32'd16);
        axi_read(32'h10, 1'b0, '0, rd, resp);
        check("irq_status_txovf", rd, 32'hA);
        axi_write(32'h10, 32'h8, resp);
        check("w1c_resp", resp, 32'd0);
        axi_read(32'h10, 1'b0, '0, rd, resp);
        check("irq_status_cleared", rd, 32'h2);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_order_%0d", i), tx_data, tx_exp[i]);
            tx_pop = 1'b1;
            tick();
            tx_pop = 1'b0;
        end
        check("tx_drained", tx_empty, 32'd1);

        // Basic RX pops and underflow
        rx_push = 1'b1; rx_data = 32'h11; tick();
        rx_data = 32'h22; tick();
        rx_push = 1'b0;
        axi_read(32'h04, 1'b0, '0, rd, resp);
        check("rx_rd1_data", rd, 32'h11);
        check("rx_rd1_resp", resp, 32'd0);
        axi_read(32'h04, 1'b0, '0, rd, resp);
        check("rx_rd2_data", rd, 32'h22);
        check("rx_rd2_resp", resp, 32'd0);
        axi_read(32'h04, 1'b0, '0, rd, resp);
        check("rx_empty_data", rd, 32'h0);
        check("rx_empty_resp", resp, 32'd2);

        // Unmapped and read-only targets
        axi_write(32'h04, 32'h1234, resp);
        check("wr_rxdata_resp", resp, 32'd2);
        axi_write(32'h14, 32'h1234, resp);
        check("wr_hole_resp", resp, 32'd2);
        axi_read(32'h18, 1'b0, '0, rd, resp);
        check("rd_hole_data", rd, 32'h0);
        check("rd_hole_resp", resp, 32'd2);

        // RX full with simultaneous push and pop; order across pointer wrap
        for (int i = 0; i < 16; i++) begin
            rx_push = 1'b1; rx_data = 32'h1000 + i; tick();
        end
        rx_push = 1'b0;
        check("rx_full", rx_full, 32'd1);
        for (int i = 16; i < 40; i++) begin
            axi_read(32'h04, 1'b1, 32'h1000 + i, rd, resp);
            check($sformatf("rx_wrap_%0d", i - 16), rd, 32'h1000 + i - 16);
            if (i == 16) check("rx_level_pushpop", rx_level, 32'd16);
        end
        check("rx_level_still_full", rx_level, 32'd16);
        for (int j = 0; j < 16; j++) begin
            axi_read(32'h04, 1'b0, '0, rd, resp);
            check($sformatf("rx_tail_%0d", j), rd, 32'h1000 + 24 + j);
        end
        axi_read(32'h10, 1'b0, '0, rd, resp);
        check("no_rx_ovf", rd, 32'h3);

        // RX high threshold drives irq; rx_flush clears it
        axi_write(32'h0C, 32'h0004_0000, resp);
        axi_write(32'h08, 32'h8, resp);
        check("irq_idle", irq, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rx_push = 1'b1; rx_data = 32'h50 + i; tick();
        end
        rx_push = 1'b0;
        check("irq_lag", irq, 32'd0);
        tick();
        check("irq_rx_high", irq, 32'd1);
        axi_write(32'h08, 32'hA, resp);
        check("flush_rx_level", rx_level, 32'd0);
        check("flush_irq", irq, 32'd0);
        axi_read(32'h08, 1'b0, '0, rd, resp);
        check("ctrl_readback", rd, 32'h8);
        axi_read(32'h0C, 1'b0, '0, rd, resp);
        check("thresh_readback", rd, 32'h0004_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
